rf_port_arbiter: RTL and testbench

- Controller in front of the single-port register file (one read or one write per clock, read data registered one cycle after the address).
- Shares the port between NREQ requesters (e.g. decode operand reads, writeback) using round-robin valid/ready arbitration.
- Returns read data with a one-cycle response strobe.
- After reset, sequences a zero-fill sweep of every register, because the register file itself has no reset.

---
 rtl/rf_arb_pkg.sv | 10 +
 rtl/rr_arbiter.sv | 33 +++
 rtl/rf_port_arbiter.sv | 82 ++++++++
 tb/tb_rf_port_arbiter.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/rf_arb_pkg.sv
// rf_arb_pkg: shared types, default sizes and helpers for the register-file port arbiter.
package rf_arb_pkg;
  typedef enum logic {INIT, ARB} state_t;
  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int NREGS_DEF  = 32;
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin one-hot grant with a rotating priority pointer.
module rr_arbiter #(
  parameter int NREQ = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         i_valid,
  input  logic                    i_en,
  output logic [NREQ-1:0]         o_grant,
  output logic [$clog2(NREQ)-1:0] o_idx
);
  localparam int PW = $clog2(NREQ);
  logic [PW-1:0] r_ptr;
  logic [PW-1:0] w_j;
  logic          w_found;
  always_comb begin
    o_grant = '0;
    o_idx   = r_ptr;
    w_found = 1'b0;
    w_j     = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_j = PW'((int'(r_ptr) + k) % NREQ);
      if (!w_found && i_en && i_valid[w_j]) begin
        o_grant[w_j] = 1'b1;
        o_idx        = w_j;
        w_found      = 1'b1;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_ptr <= '0;
    else if (w_found) r_ptr <= (o_idx == PW'(NREQ - 1)) ? '0 : o_idx + 1'b1;
endmodule

// File: rtl/rf_port_arbiter.sv
// rf_port_arbiter: zero-fill sweep then round-robin sharing of a single-port register file.
// Optional: RFARB_ZERO_REG_EN makes address 0 a hardwired zero register.
module rf_port_arbiter
  import rf_arb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NREGS  = NREGS_DEF,
  parameter int NREQ   = 2
) (
  input  logic                   clkout,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ-1:0]        req_we,
  input  logic [NREQ*ADDR_W-1:0] req_addr,
  input  logic [NREQ*DATA_W-1:0] req_wdata,
  output logic [NREQ-1:0]        req_ready,
  output logic [NREQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]      rsp_rdata,
  output logic                   init_done,
  output logic                   rf_sal,
  output logic [ADDR_W-1:0]      rf_addr,
  output logic [DATA_W-1:0]      rf_result,
  input  logic [DATA_W-1:0]      rf_rdata
);
  localparam int CW = cnt_w(NREGS);
  localparam int IW = $clog2(NREQ);
  state_t              r_state, w_next;
  logic [CW-1:0]       r_cnt;
  logic [NREQ-1:0]     r_rsp;
  logic                r_zero;
  logic [NREQ-1:0]     w_grant;
  logic [IW-1:0]       w_idx;
  logic                w_gnt, w_we, w_zero;
  logic [ADDR_W-1:0]   w_addr;
  logic [DATA_W-1:0]   w_wdata;

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .clk     (clkout),
    .rst_n   (rst_n),
    .i_valid (req_valid),
    .i_en    (r_state == ARB),
    .o_grant (w_grant),
    .o_idx   (w_idx)
  );

  assign w_gnt   = |w_grant;
  assign w_we    = req_we[w_idx];
  assign w_addr  = req_addr[w_idx*ADDR_W +: ADDR_W];
  assign w_wdata = req_wdata[w_idx*DATA_W +: DATA_W];
`ifdef RFARB_ZERO_REG_EN
  assign w_zero = (w_addr == '0);
`else
  assign w_zero = 1'b0;
`endif

  always_ff @(posedge clkout or negedge rst_n)
    if (!rst_n) begin
      r_state <= INIT;
      r_cnt   <= '0;
      r_rsp   <= '0;
      r_zero  <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == INIT) r_cnt <= r_cnt + 1'b1;
      r_rsp   <= w_grant & {NREQ{~w_we}};
      r_zero  <= w_gnt & ~w_we & w_zero;
    end

  always_comb w_next = (r_state == INIT && r_cnt == CW'(NREGS - 1)) ? ARB : r_state;

  // Idle cycles issue a harmless read of address 0 with no response.
  always_comb begin
    req_ready = w_grant;
    rsp_valid = r_rsp;
    rsp_rdata = r_zero ? '0 : rf_rdata;
    init_done = (r_state == ARB);
    rf_sal    = (r_state == INIT) | (w_gnt & w_we & ~w_zero);
    rf_addr   = (r_state == INIT) ? ADDR_W'(r_cnt) : w_gnt ? w_addr : '0;
    rf_result = (r_state == ARB && w_gnt) ? w_wdata : '0;
  end
endmodule

// File: tb/tb_rf_port_arbiter.sv
// tb_rf_port_arbiter: directed checks of sweep, arbitration, responses and resets.
module tb_rf_port_arbiter;
  logic        clkout = 1'b0;
  logic        rst_n  = 1'b0;
  logic [1:0]  req_valid, req_we, req_ready, rsp_valid;
  logic [9:0]  req_addr;
  logic [63:0] req_wdata;
  logic [31:0] rsp_rdata, rf_result, rf_rdata;
  logic        init_done, rf_sal;
  logic [4:0]  rf_addr;
  logic [31:0] mem [32];
  logic        seeded = 1'b0;
  logic [1:0]  g [4];
  int          n_tests = 0;
  int          n_fail  = 0;

  always #5 clkout = ~clkout;

  rf_port_arbiter dut (
    .clkout    (clkout),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .init_done (init_done),
    .rf_sal    (rf_sal),
    .rf_addr   (rf_addr),
    .rf_result (rf_result),
    .rf_rdata  (rf_rdata)
  );

  // Register file model: garbage at power-up, registered read data.
  always @(posedge clkout)
    if (!seeded) begin
      for (int i = 0; i < 32; i++) mem[i] <= 32'hA5A5_0000 | i;
      seeded <= 1'b1;
    end else begin
      if (rf_sal) mem[rf_addr] <= rf_result;
      rf_rdata <= mem[rf_addr];
    end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clkout);
    #1;
  endtask

  initial begin
    req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    #22;
    check("rst_done", 32'(init_done), 32'd0);
    check("rst_rsp", 32'(rsp_valid), 32'd0);
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_addr", 32'(rf_addr), 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      check("sw1_sal", 32'(rf_sal), 32'd1);
      check("sw1_addr", 32'(rf_addr), i);
      tick;
    end
    check("sw1_addr10", 32'(rf_addr), 32'd10);
    rst_n = 1'b0;
    #1;
    check("mid_rst_addr", 32'(rf_addr), 32'd0);
    check("mid_rst_done", 32'(init_done), 32'd0);
    #1;
    req_valid = 2'b10; req_we = 2'b00; req_addr[9:5] = 5'd3;
    rst_n = 1'b1;
    for (int i = 0; i < 32; i++) begin
      check("sw2_sal", 32'(rf_sal), 32'd1);
      check("sw2_addr", 32'(rf_addr), i);
      check("sw2_result", rf_result, 32'd0);
      check("sw2_ready", 32'(req_ready), 32'd0);
      check("sw2_done", 32'(init_done), 32'd0);
      tick;
    end
    check("arb_done", 32'(init_done), 32'd1);
    check("held_ready", 32'(req_ready), 32'd2);
    check("held_sal", 32'(rf_sal), 32'd0);
    check("held_addr", 32'(rf_addr), 32'd3);
    tick;
    req_valid = 2'b00;
    #1;
    check("held_rsp", 32'(rsp_valid), 32'd2);
    check("held_rdata", rsp_rdata, 32'd0);
    check("idle_ready", 32'(req_ready), 32'd0);
    check("idle_sal", 32'(rf_sal), 32'd0);
    check("idle_addr", 32'(rf_addr), 32'd0);
    req_valid = 2'b01; req_we = 2'b01; req_addr[4:0] = 5'd5; req_wdata[31:0] = 32'hDEADBEEF;
    #1;
    check("wr_ready", 32'(req_ready), 32'd1);
    check("wr_sal", 32'(rf_sal), 32'd1);
    check("wr_addr", 32'(rf_addr), 32'd5);
    check("wr_result", rf_result, 32'hDEADBEEF);
    tick;
    req_we = 2'b00;
    #1;
    check("rd_ready", 32'(req_ready), 32'd1);
    check("rd_sal", 32'(rf_sal), 32'd0);
    check("wr_no_rsp", 32'(rsp_valid), 32'd0);
    tick;
    req_valid = 2'b00;
    #1;
    check("rd_rsp", 32'(rsp_valid), 32'd1);
    check("rd_rdata", rsp_rdata, 32'hDEADBEEF);
    // Pointer sits at 1 after two grants to requester 0.
    g = '{2'b10, 2'b01, 2'b10, 2'b01};
    req_addr = {5'd2, 5'd1}; req_we = 2'b00; req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("alt_ready", 32'(req_ready), 32'(g[k]));
      check("alt_addr", 32'(rf_addr), (g[k] == 2'b01) ? 32'd1 : 32'd2);
      if (k > 0) begin
        check("alt_rsp", 32'(rsp_valid), 32'(g[k-1]));
        check("alt_rdata", rsp_rdata, 32'd0);
      end
      tick;
    end
    req_valid = 2'b00;
    #1;
    check("alt_rsp_last", 32'(rsp_valid), 32'(g[3]));
    check("alt_rdata_last", rsp_rdata, 32'd0);
    req_valid = 2'b01; req_we = 2'b01; req_addr[4:0] = 5'd0; req_wdata[31:0] = 32'h1234;
    #1;
    check("z_wr_ready", 32'(req_ready), 32'd1);
`ifdef RFARB_ZERO_REG_EN
    check("z_wr_sal", 32'(rf_sal), 32'd0);
`else
    check("z_wr_sal", 32'(rf_sal), 32'd1);
`endif
    tick;
    req_we = 2'b00;
    #1;
    check("z_rd_ready", 32'(req_ready), 32'd1);
    tick;
    req_valid = 2'b00;
    #1;
    check("z_rsp", 32'(rsp_valid), 32'd1);
`ifdef RFARB_ZERO_REG_EN
    check("z_rdata", rsp_rdata, 32'd0);
`else
    check("z_rdata", rsp_rdata, 32'h1234);
`endif
    req_valid = 2'b01; req_we = 2'b00; req_addr[4:0] = 5'd5;
    #1;
    tick;
    req_valid = 2'b00;
    #1;
    check("pend_rsp", 32'(rsp_valid), 32'd1);
    check("pend_rdata", rsp_rdata, 32'hDEADBEEF);
    rst_n = 1'b0;
    #1;
    check("pend_rst_rsp", 32'(rsp_valid), 32'd0);
    check("pend_rst_done", 32'(init_done), 32'd0);
    check("pend_rst_sal", 32'(rf_sal), 32'd1);
    check("pend_rst_addr", 32'(rf_addr), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
